vga_frame_ctrl: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 37 +++
 rtl/vga_frame_ctrl_counter.sv | 47 ++++
 rtl/vga_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_vga_frame_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants, sync-window helpers and the update FSM state type.
package vga_timing_pkg;

  localparam int H_VIS_PX   = 640;
  localparam int H_FP_PX    = 16;
  localparam int H_SYNC_PX  = 96;
  localparam int H_BP_PX    = 48;
  localparam int H_TOT_PX   = H_VIS_PX + H_FP_PX + H_SYNC_PX + H_BP_PX;

  localparam int V_VIS_LN   = 480;
  localparam int V_FP_LN    = 10;
  localparam int V_SYNC_LN  = 2;
  localparam int V_BP_LN    = 33;
  localparam int V_TOT_LN   = V_VIS_LN + V_FP_LN + V_SYNC_LN + V_BP_LN;

  // First position of the sync pulse on an axis.
  function automatic int syncStart(input int vis, input int fp);
    return vis + fp;
  endfunction

  // Last position (inclusive) of the sync pulse on an axis.
  function automatic int syncEnd(input int vis, input int fp, input int sync);
    return vis + fp + sync - 1;
  endfunction

  localparam int H_SYNC_START = syncStart(H_VIS_PX, H_FP_PX);
  localparam int H_SYNC_END   = syncEnd(H_VIS_PX, H_FP_PX, H_SYNC_PX);
  localparam int V_SYNC_START = syncStart(V_VIS_LN, V_FP_LN);
  localparam int V_SYNC_END   = syncEnd(V_VIS_LN, V_FP_LN, V_SYNC_LN);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PENDING = 2'b01,
    ACK     = 2'b10
  } upd_state_t;

endpackage

// File: rtl/vga_frame_ctrl_counter.sv
// Wrap-around axis counter. countNext is exposed so the parent can decode
// registered flags that line up with the count on the same cycle.
module vga_axis_counter #(
  parameter int CW  = 11,
  parameter int TOT = 800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic [CW-1:0] countNext,
  output logic          wrap
);

  localparam logic [CW-1:0] LAST = CW'(TOT - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_r;

  // Next-count and wrap strobe: advance when enabled, return to zero after LAST.
  always_comb begin
    wrap      = 1'b0;
    countNext = count_r;
    if (en) begin
      if (count_r == LAST) begin
        wrap      = 1'b1;
        countNext = {CW{1'b0}};
      end else begin
        countNext = count_r + ONE;
      end
    end else begin
      countNext = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= countNext;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/vga_frame_ctrl.sv
// VGA frame sequencer: pixel/line counters, registered syncs and flags, and a
// displayed-time register that only changes on entry to vertical blank.
module vga_frame_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_VIS  = H_VIS_PX,
  parameter int H_FP   = H_FP_PX,
  parameter int H_SYNC = H_SYNC_PX,
  parameter int H_BP   = H_BP_PX,
  parameter int V_VIS  = V_VIS_LN,
  parameter int V_FP   = V_FP_LN,
  parameter int V_SYNC = V_SYNC_LN,
  parameter int V_BP   = V_BP_LN,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          upd_req,
  input  logic [23:0]   time_in,
  output logic          upd_ack,
  output logic [23:0]   time_q,
  output logic [CW-1:0] countH,
  output logic [CW-1:0] countV,
  output logic          h_sinc,
  output logic          v_sinc,
  output logic          video_on,
  output logic          frame_start
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_VBLANK = CW'(V_VIS - 1);
  localparam logic [CW-1:0] H_VIS_C  = CW'(H_VIS);
  localparam logic [CW-1:0] V_VIS_C  = CW'(V_VIS);
  localparam logic [CW-1:0] HS_START = CW'(syncStart(H_VIS, H_FP));
  localparam logic [CW-1:0] HS_END   = CW'(syncEnd(H_VIS, H_FP, H_SYNC));
  localparam logic [CW-1:0] VS_START = CW'(syncStart(V_VIS, V_FP));
  localparam logic [CW-1:0] VS_END   = CW'(syncEnd(V_VIS, V_FP, V_SYNC));

  logic [CW-1:0] hNext_s, vNext_s;
  logic          hWrap_s, vWrap_s;
  logic          vblankEntry_s, commit_s;
  logic          hSinc_r, vSinc_r, videoOn_r, frameStart_r, updAck_r;
  logic [23:0]   timeQ_r;
  upd_state_t    state_r, stateNext_s;

  vga_axis_counter #(.CW(CW), .TOT(H_TOT)) uHCnt (
    .clk       (clk),
    .rst       (rst),
    .en        (1'b1),
    .count     (countH),
    .countNext (hNext_s),
    .wrap      (hWrap_s)
  );

  vga_axis_counter #(.CW(CW), .TOT(V_TOT)) uVCnt (
    .clk       (clk),
    .rst       (rst),
    .en        (hWrap_s),
    .count     (countV),
    .countNext (vNext_s),
    .wrap      (vWrap_s)
  );

  // Syncs and flags decoded from the next counts so they match countH/countV.
  // The vertical wrap strobe fires exactly when the next position is (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hSinc_r      <= 1'b1;
      vSinc_r      <= 1'b1;
      videoOn_r    <= 1'b1;
      frameStart_r <= 1'b1;
    end else begin
      hSinc_r      <= !((hNext_s >= HS_START) && (hNext_s <= HS_END));
      vSinc_r      <= !((vNext_s >= VS_START) && (vNext_s <= VS_END));
      videoOn_r    <= (hNext_s < H_VIS_C) && (vNext_s < V_VIS_C);
      frameStart_r <= vWrap_s;
    end
  end

  // Last pixel of the last visible line: the edge out of it enters vblank.
  assign vblankEntry_s = (countH == H_LAST) && (countV == V_VBLANK);

  // Update FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Update FSM next state; a dropped request always wins over a commit.
  always_comb begin
    stateNext_s = state_r;
    commit_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (upd_req) stateNext_s = PENDING;
        else         stateNext_s = IDLE;
      end
      PENDING: begin
        if (!upd_req) begin
          stateNext_s = IDLE;
        end else if (vblankEntry_s) begin
          commit_s    = 1'b1;
          stateNext_s = ACK;
        end else begin
          stateNext_s = PENDING;
        end
      end
      ACK: begin
        if (!upd_req) stateNext_s = IDLE;
        else          stateNext_s = ACK;
      end
      default: stateNext_s = IDLE;
    endcase
  end

  // Committed digits and the one-cycle acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeQ_r  <= 24'h000000;
      updAck_r <= 1'b0;
    end else begin
      updAck_r <= commit_s;
      if (commit_s) timeQ_r <= time_in;
      else          timeQ_r <= timeQ_r;
    end
  end

  assign h_sinc      = hSinc_r;
  assign v_sinc      = vSinc_r;
  assign video_on    = videoOn_r;
  assign frame_start = frameStart_r;
  assign upd_ack     = updAck_r;
  assign time_q      = timeQ_r;

endmodule

// File: tb/tb_vga_frame_ctrl.sv
// Directed bench: a full-size instance for reset and line timing, and a
// shrunken-timing instance (24x16 totals) for frame and update behaviour.
module tb_vga_frame_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;

  // Full-size instance (default 640x480 timing)
  logic        fReq = 1'b0;
  logic [23:0] fTin = 24'h000000;
  logic        fAck, fHs, fVs, fVo, fFs;
  logic [23:0] fTq;
  logic [10:0] fH, fV;

  // Small instance: H 16+2+3+3=24 (sync 18..20), V 10+2+2+2=16 (sync 12..13)
  logic        sReq = 1'b0;
  logic [23:0] sTin = 24'h000000;
  logic        sAck, sHs, sVs, sVo, sFs;
  logic [23:0] sTq;
  logic [5:0]  sH, sV;

  int nPass  = 0;
  int nTotal = 0;
  int ackCnt = 0;

  vga_frame_ctrl dutF (
    .clk(clk), .rst(rst), .upd_req(fReq), .time_in(fTin), .upd_ack(fAck),
    .time_q(fTq), .countH(fH), .countV(fV), .h_sinc(fHs), .v_sinc(fVs),
    .video_on(fVo), .frame_start(fFs)
  );

  vga_frame_ctrl #(
    .H_VIS(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(10), .V_FP(2), .V_SYNC(2), .V_BP(2), .CW(6)
  ) dutS (
    .clk(clk), .rst(rst), .upd_req(sReq), .time_in(sTin), .upd_ack(sAck),
    .time_q(sTq), .countH(sH), .countV(sV), .h_sinc(sHs), .v_sinc(sVs),
    .video_on(sVo), .frame_start(sFs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTotal++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (sAck) ackCnt++;
  endtask

  // Advance the small instance to position (h,v) within a cycle budget.
  task automatic waitPos(input string tag, input int h, input int v);
    int n = 0;
    while (!(int'(sH) == h && int'(sV) == v) && n < 500) begin
      tick();
      n++;
    end
    chk(tag, (int'(sH) == h && int'(sV) == v), 1);
  endtask

  initial begin
    int first, lows, vo640, vsLow, voCnt, fsCnt, errCnt, n;

    // ---------------- reset ----------------
    #2 rst = 1'b1;
    repeat (3) tick();
    chk("rst_fH", fH, 0);        chk("rst_fV", fV, 0);
    chk("rst_fHs", fHs, 1);      chk("rst_fVs", fVs, 1);
    chk("rst_fVo", fVo, 1);      chk("rst_fFs", fFs, 1);
    chk("rst_fAck", fAck, 0);    chk("rst_fTq", fTq, 0);
    chk("rst_sH", sH, 0);        chk("rst_sV", sV, 0);
    chk("rst_sTq", sTq, 0);      chk("rst_sAck", sAck, 0);

    // ---------------- first line, full size ----------------
    rst = 1'b0;
    tick();
    chk("first_fH", fH, 1);
    chk("first_fFs", fFs, 0);
    first = -1; lows = 0; vo640 = 1;
    for (int k = 2; k <= 799; k++) begin
      tick();
      if (!fHs) begin
        if (first < 0) first = int'(fH);
        lows++;
      end
      if (fH == 11'd640) vo640 = int'(fVo);
    end
    chk("hs_first_low", first, 656);
    chk("hs_low_len", lows, 96);
    chk("vo_at_640", vo640, 0);
    tick();
    chk("wrap_fH", fH, 0);
    chk("wrap_fV", fV, 1);

    // ---------------- full frame, small instance ----------------
    n = 0;
    while (!sFs && n < 500) begin tick(); n++; end
    chk("fs_seen", sFs, 1);
    vsLow = 0; voCnt = 0; fsCnt = 0; errCnt = 0;
    for (int i = 1; i <= 384; i++) begin
      tick();
      if (!sVs) vsLow++;
      if (sVo) voCnt++;
      if (sFs) fsCnt++;
      if (sVs !== !(sV >= 6'd12 && sV <= 6'd13)) errCnt++;
      if (sHs !== !(sH >= 6'd18 && sH <= 6'd20)) errCnt++;
      if (sVo !== (sH < 6'd16 && sV < 6'd10)) errCnt++;
      if (sFs !== (sH == 6'd0 && sV == 6'd0)) errCnt++;
    end
    chk("vs_low_cycles", vsLow, 48);
    chk("vo_cycles", voCnt, 160);
    chk("fs_per_frame", fsCnt, 1);
    chk("fs_period_end", sFs, 1);
    chk("decode_errs", errCnt, 0);

    // ---------------- commit ----------------
    waitPos("pos_c0", 0, 3);
    sReq = 1'b1; sTin = 24'h123456; ackCnt = 0;
    waitPos("pos_c1", 23, 9);
    chk("pre_commit_tq", sTq, 24'h000000);
    chk("pre_commit_ack", ackCnt, 0);
    tick();
    chk("commit_pos_v", sV, 10);
    chk("commit_tq", sTq, 24'h123456);
    chk("commit_ack", sAck, 1);
    tick();
    chk("ack_one_cycle", sAck, 0);
    sReq = 1'b0;

    // ---------------- abort ----------------
    waitPos("pos_a0", 0, 2);
    sReq = 1'b1; sTin = 24'h235959; ackCnt = 0;
    waitPos("pos_a1", 0, 7);
    sReq = 1'b0;
    waitPos("pos_a2", 0, 11);
    chk("abort_ack", ackCnt, 0);
    chk("abort_tq", sTq, 24'h123456);

    // ---------------- hold after ack ----------------
    waitPos("pos_h0", 0, 2);
    sReq = 1'b1; sTin = 24'h000001; ackCnt = 0;
    for (int i = 0; i < 3 * 384; i++) begin
      tick();
      if (sAck) sTin = 24'h999999;
    end
    chk("hold_acks", ackCnt, 1);
    chk("hold_tq", sTq, 24'h000001);
    sReq = 1'b0;

    // ---------------- request rising in vblank-entry cycle ----------------
    waitPos("pos_r0", 23, 9);
    sReq = 1'b1; sTin = 24'h111111; ackCnt = 0;
    tick();
    chk("late_req_tq", sTq, 24'h000001);
    chk("late_req_ack", ackCnt, 0);
    waitPos("pos_r1", 23, 9);
    tick();
    chk("next_frame_tq", sTq, 24'h111111);
    chk("next_frame_ack", sAck, 1);
    sReq = 1'b0;

    // ---------------- request dropping in vblank-entry cycle ----------------
    waitPos("pos_d0", 0, 2);
    sReq = 1'b1; sTin = 24'h222222; ackCnt = 0;
    waitPos("pos_d1", 23, 9);
    sReq = 1'b0;
    tick();
    chk("drop_wins_tq", sTq, 24'h111111);
    chk("drop_wins_ack", ackCnt, 0);

    // ---------------- reset mid-PENDING ----------------
    waitPos("pos_m0", 0, 8);
    sReq = 1'b1; sTin = 24'h654321;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_sH", sH, 0);
    chk("mid_rst_sV", sV, 0);
    chk("mid_rst_tq", sTq, 24'h000000);
    tick();
    sReq = 1'b0;
    rst = 1'b0;
    ackCnt = 0;
    tick();
    chk("post_rst_sH", sH, 1);
    chk("post_rst_sV", sV, 0);
    waitPos("pos_m1", 0, 11);
    chk("post_rst_ack", ackCnt, 0);
    chk("post_rst_tq", sTq, 24'h000000);

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
